// File: rtl/zigzag_reorder_buf.sv
// Ping-pong 8x8 coefficient buffer: fills one bank in raster order while the other
// drains in JPEG zigzag order straight into a stallable output register.
module zigzag_reorder_buf #(
  parameter int DWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sob,
  output logic              out_eob
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  logic [DWIDTH-1:0] mem [128];
  logic [1:0]        full, full_nxt;
  logic              wr_bank, rd_bank, rd_bank_nxt;
  logic [5:0]        wr_cnt, rd_cnt;
  state_t            state, state_nxt;
  logic              wr_fire, wr_done, adv, rd_fire, rd_done;

  assign in_ready = ~full[wr_bank];
  assign wr_fire  = in_valid & in_ready;
  assign wr_done  = wr_fire & (wr_cnt == 6'd63);
  assign adv      = ~out_valid | out_ready;
  assign rd_fire  = (state == DRAIN) & adv;
  assign rd_done  = rd_fire & (rd_cnt == 6'd63);

  // Next state looks at next-cycle flags so a block completing this cycle
  // starts draining on the very next cycle (two-cycle in-to-out latency).
  always_comb begin
    full_nxt    = full;
    rd_bank_nxt = rd_bank ^ rd_done;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    state_nxt   = full_nxt[rd_bank_nxt] ? DRAIN : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= 6'd0;
      rd_cnt  <= 6'd0;
    end else begin
      state   <= state_nxt;
      full    <= full_nxt;
      rd_bank <= rd_bank_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (rd_fire) rd_cnt <= rd_cnt + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !rst) mem[{wr_bank, wr_cnt}] <= in_data;
  end

  // The RAM read register doubles as the output register; a read is only
  // issued when the presented beat is leaving, so backpressure simply freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
    end else if (adv) begin
      out_valid <= rd_fire;
      if (rd_fire) begin
        out_data <= mem[{rd_bank, ZZ[rd_cnt]}];
        out_sob  <= (rd_cnt == 6'd0);
        out_eob  <= (rd_cnt == 6'd63);
      end else begin
        out_sob  <= 1'b0;
        out_eob  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zigzag_reorder_buf.sv
// Randomized bench for zigzag_reorder_buf against a queue-based block/zigzag model.
module tb_zigzag_reorder_buf;
  localparam int DW = 12;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_sob, out_eob;
  logic [DW-1:0] out_data;

  zigzag_reorder_buf #(.DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sob(out_sob), .out_eob(out_eob));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int zz_ord [64];
  int partial [$];
  int exp_q [$];
  int src [$];
  int ob_idx = 0;
  bit lat_arm = 0, gap_en = 0, have_last = 0;
  int t_in = -1, t_out = -1, last_out = 0, gaps = 0;
  bit stall_prev = 0;
  logic [DW-1:0] prev_d;
  logic prev_sob, prev_eob;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: collect raster blocks, emit in zigzag order built by diagonal walk.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_d);
        chk("hold_sob", out_sob, prev_sob);
        chk("hold_eob", out_eob, prev_eob);
      end
      if (in_valid && in_ready) begin
        partial.push_back(int'($signed(in_data)));
        if (partial.size() == 64) begin
          for (int i = 0; i < 64; i++) exp_q.push_back(partial[zz_ord[i]]);
          partial.delete();
          if (lat_arm && t_in < 0) t_in = cyc;
        end
      end
      if (lat_arm && out_valid && t_out < 0) t_out = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("out_data", int'($signed(out_data)), exp_q.pop_front());
          chk("out_sob", out_sob, ob_idx == 0);
          chk("out_eob", out_eob, ob_idx == 63);
          ob_idx = (ob_idx + 1) % 64;
        end
        if (gap_en) begin
          if (have_last && cyc != last_out + 1) gaps++;
          last_out = cyc;
          have_last = 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_d = out_data; prev_sob = out_sob; prev_eob = out_eob;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 out_ready low, 1 high, 2 random
  task automatic offer(input int nmax, input int max_cyc, input int rmode, input bit vrand,
                       output int acc, output int stalls);
    acc = 0; stalls = 0;
    for (int c = 0; c < max_cyc && acc < nmax; c++) begin
      in_valid  = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = DW'(src[acc]);
      out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
      @(negedge clk);
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int c;
    in_valid = 1'b0; out_ready = 1'b1; c = 0;
    while (exp_q.size() > 0 && c < max_cyc) begin step(); c++; end
    step(); step();
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    int acc, stalls, k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 8) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz_ord[k] = r*8 + s - r; k++; end
      else            for (int r = lo; r <= hi; r++) begin zz_ord[k] = r*8 + s - r; k++; end
    end

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sob", out_sob, 0);
    chk("rst_out_eob", out_eob, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);

    // 1: single ramp block, latency
    src.delete(); for (int i = 0; i < 64; i++) src.push_back(i);
    lat_arm = 1;
    offer(64, 200, 1, 0, acc, stalls);
    drain(200);
    lat_arm = 0;
    chk("t1_acc", acc, 64);
    chk("t1_latency", t_out - t_in, 2);

    // 2: three back-to-back blocks
    src.delete(); for (int i = 0; i < 192; i++) src.push_back(i);
    gap_en = 1; have_last = 0; gaps = 0;
    offer(192, 400, 1, 0, acc, stalls);
    drain(300);
    gap_en = 0;
    chk("t2_acc", acc, 192);
    chk("t2_in_stalls", stalls, 0);
    chk("t2_out_gaps", gaps, 0);

    // 3: full backpressure
    src.delete(); for (int i = 0; i < 200; i++) src.push_back($urandom_range(0, 4095) - 2048);
    offer(200, 200, 0, 0, acc, stalls);
    chk("t3_acc", acc, 128);
    chk("t3_in_ready_low", in_ready, 0);
    drain(400);
    chk("t3_in_ready_back", in_ready, 1);

    // 4: random handshakes, negative data
    src.delete(); for (int i = 0; i < 512; i++) src.push_back(-2048 + int'($urandom_range(0, 63)));
    offer(512, 6000, 2, 1, acc, stalls);
    chk("t4_acc", acc, 512);
    drain(600);

    // 5: reset mid-block discards partial data
    src.delete(); for (int i = 0; i < 40; i++) src.push_back(1000 + i);
    offer(40, 100, 1, 0, acc, stalls);
    rst = 1'b1; step(); rst = 1'b0;
    partial.delete(); ob_idx = 0;
    chk("t5_post_rst_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (5) step();
    chk("t5_idle_valid", out_valid, 0);
    src.delete(); for (int i = 0; i < 64; i++) src.push_back(100 + i);
    offer(64, 200, 1, 0, acc, stalls);
    drain(200);

    // 6: mid-block hold
    src.delete(); for (int i = 0; i < 64; i++) src.push_back($urandom_range(0, 2047));
    offer(64, 200, 0, 0, acc, stalls);
    out_ready = 1'b1;
    repeat (20) step();
    out_ready = 1'b0;
    repeat (10) step();
    chk("t6_held_valid", out_valid, 1);
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
